// File: rtl/sort_pkg.sv
// Shared definitions for the sequential bubble sorter.
//   - sort_state_e : controller states (LOAD, SORT, OUT)
//   - SORT_N_DEF / SORT_W_DEF : default words-per-batch and word width
//   - swap_cnt_w() : width of a counter able to hold N*(N-1)/2 swaps
package sort_pkg;

  localparam int SORT_N_DEF = 4;
  localparam int SORT_W_DEF = 4;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SORT = 2'd1,
    OUT  = 2'd2
  } sort_state_e;

  // Bubble sort performs at most one swap per inversion, i.e. N*(N-1)/2.
  function automatic int swap_cnt_w(input int n);
    return $clog2(n * (n - 1) / 2 + 1);
  endfunction

endpackage

// File: rtl/mag_cmp.sv
// Purely combinational W-bit unsigned magnitude comparator.
// Ports:
//   a, b : operands (unsigned, W bits)
//   eq   : a == b
//   gt   : a >  b
//   lt   : a <  b
// Exactly one of eq/gt/lt is high for any pair of known operands.
module mag_cmp #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq,
  output logic         gt,
  output logic         lt
);

  assign eq = (a == b);
  assign gt = (a >  b);
  assign lt = (a <  b);

endmodule

// File: rtl/sort_seq.sv
// Sequential in-place bubble sorter for batches of N unsigned W-bit words.
// A batch is loaded over a valid/ready stream, sorted one compare per clock
// using a single mag_cmp on mem[k]/mem[k+1], then streamed out in order.
//
// Build option: define SORT_DESC_EN for descending output (swap when
// mem[k] < mem[k+1]); undefined gives ascending output. Handshake and cycle
// counts are identical in both builds.
//
// Ports:
//   clk        : clock, all state updates on the rising edge
//   rst_n      : synchronous active-low reset; aborts any batch in progress
//   in_valid   : in_data is valid (ignored outside LOAD)
//   in_ready   : block accepts a word this cycle
//   in_data    : unsigned input word
//   out_valid  : out_data carries a sorted word
//   out_ready  : consumer accepts out_data (ignored outside OUT)
//   out_data   : sorted word, 0 whenever out_valid is low
//   busy       : batch in progress (first word accepted, last not delivered)
//   swap_count : swaps made on the current or most recent batch
module sort_seq
  import sort_pkg::*;
#(
  parameter int N = SORT_N_DEF,
  parameter int W = SORT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_data,
  output logic                     busy,
  output logic [swap_cnt_w(N)-1:0] swap_count
);

  localparam int IW = $clog2(N);
  localparam int CW = swap_cnt_w(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [IW-1:0] PASS_MAX = IW'(N - 2);

  sort_state_e   state_q;
  sort_state_e   state_d;

  logic [W-1:0]  mem [N];
  logic [IW-1:0] load_idx;
  logic [IW-1:0] k_idx;
  logic [IW-1:0] k_nxt;
  logic [IW-1:0] p_idx;
  logic [IW-1:0] out_idx;
  logic          pass_swapped;
  logic          ready_q;

  logic          cmp_eq;
  logic          cmp_gt;
  logic          cmp_lt;
  logic          do_swap;
  logic          last_k;
  logic          sort_done;
  logic          in_xfer;
  logic          out_xfer;

  assign k_nxt = k_idx + IW'(1);

  mag_cmp #(.W(W)) u_cmp (
    .a  (mem[k_idx]),
    .b  (mem[k_nxt]),
    .eq (cmp_eq),
    .gt (cmp_gt),
    .lt (cmp_lt)
  );

  // Equal words never swap, which keeps the sort stable.
`ifdef SORT_DESC_EN
  assign do_swap = (state_q == SORT) && cmp_lt && !cmp_eq;
`else
  assign do_swap = (state_q == SORT) && cmp_gt && !cmp_eq;
`endif

  // Pass p compares k = 0 .. N-2-p.
  assign last_k    = (k_idx == (PASS_MAX - p_idx));
  // A pass with no swaps means the array is ordered; the swap decided in
  // this very cycle counts toward the current pass.
  assign sort_done = last_k && (!(pass_swapped || do_swap) || (p_idx == PASS_MAX));

  // ready_q keeps in_ready low through the reset cycle itself.
  assign in_ready  = ready_q && (state_q == LOAD);
  assign out_valid = (state_q == OUT);
  assign out_data  = out_valid ? mem[out_idx] : '0;
  assign busy      = (state_q != LOAD) || (load_idx != '0);

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (in_xfer && (load_idx == LAST_IDX)) state_d = SORT;
      SORT:    if (sort_done) state_d = OUT;
      OUT:     if (out_xfer && (out_idx == LAST_IDX)) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= LOAD;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q      <= 1'b0;
      load_idx     <= '0;
      k_idx        <= '0;
      p_idx        <= '0;
      out_idx      <= '0;
      pass_swapped <= 1'b0;
      swap_count   <= '0;
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else begin
      ready_q <= 1'b1;
      case (state_q)
        // ---- LOAD: capture words, first accept starts a fresh swap tally
        LOAD: begin
          if (in_xfer) begin
            mem[load_idx] <= in_data;
            if (load_idx == '0) swap_count <= '0;
            load_idx     <= (load_idx == LAST_IDX) ? '0 : load_idx + IW'(1);
            k_idx        <= '0;
            p_idx        <= '0;
            pass_swapped <= 1'b0;
          end
        end
        // ---- SORT: one compare (and optional swap) per cycle
        SORT: begin
          if (do_swap) begin
            mem[k_idx] <= mem[k_nxt];
            mem[k_nxt] <= mem[k_idx];
            swap_count <= swap_count + CW'(1);
          end
          pass_swapped <= pass_swapped || do_swap;
          if (last_k) begin
            if (sort_done) begin
              out_idx <= '0;
            end else begin
              p_idx        <= p_idx + IW'(1);
              k_idx        <= '0;
              pass_swapped <= 1'b0;
            end
          end else begin
            k_idx <= k_nxt;
          end
        end
        // ---- OUT: stream mem[0..N-1], holding the word while stalled
        OUT: begin
          if (out_xfer) out_idx <= (out_idx == LAST_IDX) ? '0 : out_idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_seq.sv
// Self-checking bench for sort_seq: directed batches plus randomized batches
// with random input gaps and output stalls, checked against a reference that
// sorts with a queue and derives swap count and sort latency from inversion
// counts.
module tb_sort_seq;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int CW = $clog2(N * (N - 1) / 2 + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          busy;
  logic [CW-1:0] swap_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sort_seq #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .swap_count (swap_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: sorted order from a queue sort; swaps = inversion count;
  // passes = 1 + largest number of "out of order" predecessors of any
  // element (capped at N-1); pass p costs N-1-p compare cycles.
  function automatic void model(input int w[N], output int s[N],
                                output int swaps, output int cyc);
    int q[$];
    int maxd;
    int passes;
    swaps = 0;
    maxd  = 0;
    for (int i = 0; i < N; i++) begin
      int d = 0;
      for (int j = 0; j < i; j++) begin
`ifdef SORT_DESC_EN
        if (w[j] < w[i]) d++;
`else
        if (w[j] > w[i]) d++;
`endif
      end
      swaps += d;
      if (d > maxd) maxd = d;
      q.push_back(w[i]);
    end
`ifdef SORT_DESC_EN
    q.rsort();
`else
    q.sort();
`endif
    for (int i = 0; i < N; i++) s[i] = q[i];
    passes = (maxd + 1 < N - 1) ? maxd + 1 : N - 1;
    cyc = 0;
    for (int p = 0; p < passes; p++) cyc += N - 1 - p;
  endfunction

  // Entered and left at a falling edge; leaves at the first SORT cycle.
  task automatic send(input int w[N], input bit gaps);
    for (int i = 0; i < N; i++) begin
      int t = 0;
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      if (i == 0) check("busy_idle", busy, 0);
      while (!in_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      check("in_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data  = W'(w[i]);
      @(negedge clk);
      in_valid = 1'b0;
      if (i < N - 1) check("busy_load", busy, 1);
    end
  endtask

  // Counts SORT cycles while poking the ignored inputs with noise.
  task automatic run_sort(input int exp_cyc);
    int cnt = 0;
    check("in_ready_sort", in_ready, 0);
    check("busy_sort", busy, 1);
    while (!out_valid && cnt < 64) begin
      check("out_data_idle", out_data, 0);
      cnt++;
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = W'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("sort_cycles", cnt, exp_cyc);
  endtask

  task automatic recv(input int s[N], input int swaps, input int hold_at,
                      input int hold_n, input bit rnd);
    for (int i = 0; i < N; i++) begin
      int h;
      h = (i == hold_at) ? hold_n : (rnd ? int'($urandom_range(0, 2)) : 0);
      repeat (h) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, s[i]);
        out_ready = 1'b0;
        @(negedge clk);
      end
      check("out_valid", out_valid, 1);
      check("out_data", out_data, s[i]);
      check("swap_out", swap_count, swaps);
      out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("end_valid", out_valid, 0);
    check("end_data", out_data, 0);
    check("end_busy", busy, 0);
    check("end_ready", in_ready, 1);
    check("end_swaps", swap_count, swaps);
  endtask

  task automatic batch(input int w[N], input int hold_at, input int hold_n, input bit rnd);
    int s[N];
    int swaps;
    int cyc;
    model(w, s, swaps, cyc);
    send(w, rnd);
    run_sort(cyc);
    recv(s, swaps, hold_at, hold_n, rnd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int a[N];

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_swaps", swap_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1);

    a = '{3, 1, 2, 0};     batch(a, -1, 0, 1'b0);
    a = '{0, 1, 2, 3};     batch(a, -1, 0, 1'b0);
    a = '{5, 5, 2, 5};     batch(a, -1, 0, 1'b0);
    a = '{15, 0, 15, 0};   batch(a, 1, 3, 1'b0);

    // Abort in the second SORT cycle.
    a = '{9, 8, 7, 6};
    send(a, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_swaps", swap_count, 0);
    check("abort_ready", in_ready, 0);
    check("abort_data", out_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_rel_ready", in_ready, 1);
    a = '{1, 0, 1, 0};     batch(a, -1, 0, 1'b0);

    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < N; i++)
        a[i] = int'($urandom_range(0, (it % 3 == 0) ? 1 : 15));
      batch(a, -1, 0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sort_seq.md
Name: sort_seq

Overview:
- Sequential bubble sorter that sits directly downstream of the 4-bit magnitude comparator stage and consumes its eq/gt/lt decision once per clock.
- Accepts a batch of N unsigned words over a valid/ready input stream, sorts them in place, and streams them out over a valid/ready output.
- Used to exercise the comparator in a sequential datapath and as the ordering stage ahead of result display.

Parameters:
- N, 4, words per batch; legal range 2..8.
- W, 4, word width in bits; the comparator operand width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low, sampled on the rising edge of clk.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  block accepts a word this cycle.
- in_data  in  W  unsigned input word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  W  sorted word; 0 whenever out_valid=0.
- busy  out  1  a batch is in progress: at least one word accepted, last word not yet delivered.
- swap_count  out  clog2(N*(N-1)/2+1)  number of swaps performed on the current or most recent batch.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=LOAD; indices, storage and swap_count all 0.
  - in_ready=0 during the reset cycle, 1 from the first cycle after release.
  - out_valid=0, out_data=0, busy=0.
  - Reset mid-LOAD, mid-SORT or mid-OUT aborts the batch; no partial output is produced.
- States: LOAD -> SORT -> OUT -> LOAD.
- LOAD:
  - in_ready=1; a transfer occurs when in_valid&in_ready, and the word is written to mem[load_idx]; load_idx increments.
  - The first transfer of a batch clears swap_count.
  - The transfer of word N-1 moves the state to SORT; in_ready=0 from the next cycle.
- SORT:
  - in_ready=0, out_valid=0.
  - One compare per cycle of mem[k] vs mem[k+1], with pass p=0..N-2 and k=0..N-2-p.
  - If a>b, the pair is swapped in the same edge and swap_count increments.
  - Equal words are never swapped (stable sort).
  - At the last k of a pass: if that pass made no swaps, or p=N-2, go to OUT; otherwise p++ and k=0.
  - Latency: the first compare runs in the cycle after the last accept. Sort takes N-1 cycles minimum (already sorted) and N(N-1)/2 cycles maximum.
- OUT:
  - out_valid=1 and out_data=mem[out_idx], starting at out_idx=0.
  - out_idx advances on out_valid&out_ready.
  - out_data is held stable while out_ready=0.
  - The transfer of word N-1 returns the state to LOAD; in_ready=1 in the next cycle.
  - busy falls in the same cycle that out_valid falls.
- swap_count holds its value through OUT and into LOAD until the next batch's first accept. It cannot overflow at its sized width.
- in_valid is ignored outside LOAD; out_ready is ignored outside OUT.

Optional Feature:
- Macro: SORT_DESC_EN.
- Defined: swap when mem[k] < mem[k+1], giving descending output.
- Undefined: ascending output, as described above.
- The handshake protocol and all cycle counts are identical in both builds.

Decomposition:
- Package sort_pkg holds:
  - the state enum (LOAD, SORT, OUT);
  - a localparam function for the swap_count width;
  - the default N and W constants.
- One sub-module, mag_cmp: purely combinational W-bit compare with outputs eq, gt, lt, exactly one of which is high. It is instantiated once on mem[k]/mem[k+1].

Test Plan:
- Load 3,1,2,0 with out_ready=1 -> out 0,1,2,3; swap_count=5; sort takes 6 cycles.
- Load 0,1,2,3 -> out 0,1,2,3; swap_count=0; sort exits after exactly 3 cycles.
- Load 5,5,2,5 -> out 2,5,5,5; swap_count=2 (equal words not swapped).
- Load 15,0,15,0; hold out_ready=0 for 3 cycles at the second word -> out_data holds 0, out_valid stays 1; full output 0,0,15,15; swap_count=3.
- Pull rst_n low during the 2nd SORT cycle of batch 9,8,7,6 -> next cycle out_valid=0, busy=0, swap_count=0; a new batch 1,0,1,0 then yields 0,0,1,1.
- With SORT_DESC_EN defined, load 3,1,2,0 -> out 3,2,1,0; swap_count=1.
